mem_port_arbiter: RTL and testbench

Sequences the single port of the main memory between the instruction-fetch requester and the data-memory (load/store) requester of the pipelined MIPS core. It grants one requester at a time and issues one to sixteen word-beats per transaction. It returns read data with a valid strobe and guarantees fetch forward progress under sustained load/store traffic. It sits between the fetch/memory stages and the main memory module.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and main-memory signals around the port arbiter.
// The master modport is the arbiter itself; slave is the requesters plus memory.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [0:31] if_addr;
   logic [0:1]  if_acc_size;
   logic        if_grant;
   logic        if_valid;
   logic [0:31] if_rdata;

   logic        dm_req;
   logic        dm_wren;
   logic [0:31] dm_addr;
   logic [0:31] dm_wdata;
   logic [0:1]  dm_acc_size;
   logic        dm_grant;
   logic        dm_valid;
   logic [0:31] dm_rdata;

   logic [0:31] mem_addr;
   logic [0:31] mem_data_in;
   logic [0:1]  mem_acc_size;
   logic        mem_wren;
   logic        mem_enable;
   logic [0:31] mem_data_out;
   logic        mem_busy;

   modport master (
      input  if_req, if_addr, if_acc_size,
      input  dm_req, dm_wren, dm_addr, dm_wdata, dm_acc_size,
      input  mem_data_out, mem_busy,
      output if_grant, if_valid, if_rdata,
      output dm_grant, dm_valid, dm_rdata,
      output mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
   );

   modport slave (
      output if_req, if_addr, if_acc_size,
      output dm_req, dm_wren, dm_addr, dm_wdata, dm_acc_size,
      output mem_data_out, mem_busy,
      input  if_grant, if_valid, if_rdata,
      input  dm_grant, dm_valid, dm_rdata,
      input  mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-word main-memory port between instruction fetch and load/store,
// issuing 1..16 beat bursts and forcing a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
   parameter logic [1:0] STARVE_LIMIT = 2'd3
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

   state_t      state_q;
   logic        owner_fetch_q;
   logic        rd_pending_q;
   logic        if_grant_q;
   logic        dm_grant_q;
   logic        mem_enable_q;
   logic        mem_wren_q;
   logic [1:0]  starve_q;
   logic [1:0]  starve_d;
   logic [3:0]  beat_q;
   logic [3:0]  last_q;
   logic [0:31] mem_addr_q;
   logic [0:31] mem_data_q;
   logic        grant_fetch;
   logic        grant_data;
   logic        accept;

   function automatic logic [3:0] burst_last(input logic [0:1] size);
      case (size)
         2'b00:   burst_last = 4'd0;
         2'b01:   burst_last = 4'd3;
         2'b10:   burst_last = 4'd7;
         default: burst_last = 4'd15;
      endcase
   endfunction

   always_comb begin
      grant_fetch = (state_q == IDLE) && bus.if_req &&
                    (!bus.dm_req || (starve_q == STARVE_LIMIT));
      grant_data  = (state_q == IDLE) && bus.dm_req && !grant_fetch;
      accept      = (state_q == XFER) && !bus.mem_busy;

      // Fetch waiting counts data grants; any cycle without a fetch request resets it.
      starve_d = starve_q;
      if (!bus.if_req || grant_fetch) begin
         starve_d = 2'd0;
      end else if (grant_data && (starve_q != 2'd3)) begin
         starve_d = starve_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_fetch_q <= 1'b0;
         rd_pending_q  <= 1'b0;
         if_grant_q    <= 1'b0;
         dm_grant_q    <= 1'b0;
         mem_enable_q  <= 1'b0;
         mem_wren_q    <= 1'b0;
         starve_q      <= 2'd0;
         beat_q        <= 4'd0;
         last_q        <= 4'd0;
         mem_addr_q    <= '0;
         mem_data_q    <= '0;
      end else begin
         if_grant_q   <= grant_fetch;
         dm_grant_q   <= grant_data;
         starve_q     <= starve_d;
         rd_pending_q <= accept && !mem_wren_q;

         case (state_q)
            IDLE: begin
               beat_q <= 4'd0;
               if (grant_fetch) begin
                  owner_fetch_q <= 1'b1;
                  mem_addr_q    <= bus.if_addr;
                  mem_data_q    <= '0;
                  mem_wren_q    <= 1'b0;
                  last_q        <= burst_last(bus.if_acc_size);
                  mem_enable_q  <= 1'b1;
                  state_q       <= XFER;
               end else if (grant_data) begin
                  owner_fetch_q <= 1'b0;
                  mem_addr_q    <= bus.dm_addr;
                  mem_data_q    <= bus.dm_wdata;
                  mem_wren_q    <= bus.dm_wren;
                  last_q        <= bus.dm_wren ? 4'd0 : burst_last(bus.dm_acc_size);
                  mem_enable_q  <= 1'b1;
                  state_q       <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  if (beat_q == last_q) begin
                     mem_enable_q <= 1'b0;
                     mem_wren_q   <= 1'b0;
                     state_q      <= mem_wren_q ? IDLE : DRAIN;
                  end else begin
                     beat_q     <= beat_q + 4'd1;
                     mem_addr_q <= mem_addr_q + 32'd4;
                  end
               end
            end
            DRAIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Read data is steered straight from memory in the cycle after its beat was accepted.
   assign bus.if_grant     = if_grant_q;
   assign bus.dm_grant     = dm_grant_q;
   assign bus.if_valid     = rd_pending_q && owner_fetch_q;
   assign bus.dm_valid     = rd_pending_q && !owner_fetch_q;
   assign bus.if_rdata     = bus.if_valid ? bus.mem_data_out : '0;
   assign bus.dm_rdata     = bus.dm_valid ? bus.mem_data_out : '0;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_data_in  = mem_data_q;
   assign bus.mem_acc_size = 2'b00;
   assign bus.mem_wren     = mem_wren_q;
   assign bus.mem_enable   = mem_enable_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants, beats and
// read words; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
   typedef struct {
      logic [31:0] addr;
      logic        wren;
      logic [31:0] data;
   } beat_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   req_c;
   int   if_valid_cnt = 0;
   int   if_first_cyc = 0;
   int   if_last_cyc = 0;
   int   dm_valid_cyc = 0;
   int   wr_beats = 0;

   bit          exp_grant[$];
   beat_t       exp_beat[$];
   logic [31:0] exp_if[$];
   logic [31:0] exp_dm[$];

   mem_port_arbiter_if bus();

   mem_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h80020010) return 32'h8FBF0014;
      return {a[15:0], a[31:16]} ^ 32'h5A5A5A5A;
   endfunction

   // Memory model: a read beat accepted at an edge returns its word in the next cycle.
   always @(posedge clk) begin
      if (bus.mem_enable && !bus.mem_busy && !bus.mem_wren)
         bus.mem_data_out <= mem_word(bus.mem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=strobe required=none cyc=%0d", name, cyc);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.if_grant || bus.dm_grant) begin
            $display("cyc %0d grant %s addr=%h", cyc, bus.if_grant ? "fetch" : "data",
                     bus.mem_addr);
            if (exp_grant.size() == 0) unexpected("grant_unexpected");
            else chk("grant_owner", {31'b0, bus.if_grant}, {31'b0, exp_grant.pop_front()});
         end
         if (bus.mem_enable && !bus.mem_busy) begin
            beat_t b;
            if (bus.mem_wren) wr_beats++;
            if (exp_beat.size() == 0) unexpected("beat_unexpected");
            else begin
               b = exp_beat.pop_front();
               chk("beat_addr", bus.mem_addr, b.addr);
               chk("beat_wren", {31'b0, bus.mem_wren}, {31'b0, b.wren});
               chk("beat_acc_size", {30'b0, bus.mem_acc_size}, 32'd0);
               if (b.wren) chk("beat_wdata", bus.mem_data_in, b.data);
            end
         end
         if (bus.if_valid) begin
            if (if_valid_cnt == 0) if_first_cyc = cyc;
            if_last_cyc = cyc;
            if_valid_cnt++;
            if (exp_if.size() == 0) unexpected("if_valid_unexpected");
            else chk("if_rdata", bus.if_rdata, exp_if.pop_front());
         end
         if (bus.dm_valid) begin
            dm_valid_cyc = cyc;
            if (exp_dm.size() == 0) unexpected("dm_valid_unexpected");
            else chk("dm_rdata", bus.dm_rdata, exp_dm.pop_front());
         end
      end
   end

   task automatic push_fetch(input logic [31:0] base, input int n);
      logic [31:0] a;
      exp_grant.push_back(1'b1);
      for (int i = 0; i < n; i++) begin
         a = base + 32'(4 * i);
         exp_beat.push_back('{addr: a, wren: 1'b0, data: 32'd0});
         exp_if.push_back(mem_word(a));
      end
   endtask

   task automatic push_load(input logic [31:0] base, input int n);
      logic [31:0] a;
      exp_grant.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         a = base + 32'(4 * i);
         exp_beat.push_back('{addr: a, wren: 1'b0, data: 32'd0});
         exp_dm.push_back(mem_word(a));
      end
   endtask

   task automatic push_store(input logic [31:0] a, input logic [31:0] d);
      exp_grant.push_back(1'b0);
      exp_beat.push_back('{addr: a, wren: 1'b1, data: d});
   endtask

   // who: 0 = data grant, 1 = fetch grant, 2 = either
   task automatic wait_grant(input int who, output int gcyc, output bit was_fetch);
      gcyc = -1;
      was_fetch = 1'b0;
      for (int n = 0; n < 50 && gcyc < 0; n++) begin
         @(posedge clk);
         #1;
         if ((who != 0 && bus.if_grant) || (who != 1 && bus.dm_grant)) begin
            gcyc = cyc;
            was_fetch = bus.if_grant;
         end
      end
      if (gcyc < 0) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout actual=none required=grant within 50 cycles");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_grants"}, {30'b0, bus.if_grant, bus.dm_grant}, 32'd0);
      chk({tag, "_valids"}, {30'b0, bus.if_valid, bus.dm_valid}, 32'd0);
      chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
      chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      chk({tag, "_mem_data_in"}, bus.mem_data_in, 32'd0);
      chk({tag, "_mem_ctrl"}, {28'b0, bus.mem_wren, bus.mem_enable, bus.mem_acc_size}, 32'd0);
   endtask

   task automatic wait_addr(input logic [31:0] a);
      int n = 0;
      while (n < 40 && !(bus.mem_enable && bus.mem_addr == a)) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL wait_addr_timeout actual=none required=beat at %h", a);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int g, g2, k, w0;
      bit wf;
      logic [7:0] order;

      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_acc_size = '0;
      bus.dm_req = 1'b0; bus.dm_wren = 1'b0; bus.dm_addr = '0;
      bus.dm_wdata = '0; bus.dm_acc_size = '0; bus.mem_busy = 1'b0;
      idle(2);
      chk_zero("reset");
      rst = 1'b0;
      idle(1);

      // Single load: grant after 1 cycle, data after 2
      exp_grant.push_back(1'b0);
      exp_beat.push_back('{addr: 32'h80020010, wren: 1'b0, data: 32'd0});
      exp_dm.push_back(32'h8FBF0014);
      bus.dm_wren = 1'b0; bus.dm_addr = 32'h80020010; bus.dm_acc_size = 2'b00;
      bus.dm_req = 1'b1;
      req_c = cyc;
      wait_grant(0, g, wf);
      bus.dm_req = 1'b0;
      chk("load_grant_latency", 32'(g - req_c), 32'd1);
      idle(4);
      chk("load_valid_latency", 32'(dm_valid_cyc - req_c), 32'd2);

      // 8-word fetch, memory busy for two cycles on beat 3
      push_fetch(32'h80020000, 8);
      if_valid_cnt = 0;
      bus.if_addr = 32'h80020000; bus.if_acc_size = 2'b10; bus.if_req = 1'b1;
      wait_grant(1, g, wf);
      bus.if_req = 1'b0;
      wait_addr(32'h8002000C);
      bus.mem_busy = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("busy_hold_addr", bus.mem_addr, 32'h8002000C);
         chk("busy_hold_enable", {31'b0, bus.mem_enable}, 32'd1);
      end
      bus.mem_busy = 1'b0;
      idle(12);
      chk("burst8_valid_count", 32'(if_valid_cnt), 32'd8);
      chk("burst8_first_valid", 32'(if_first_cyc - g), 32'd1);
      chk("burst8_span", 32'(if_last_cyc - if_first_cyc), 32'd9);

      // Store with size 11 is one beat; a held request is regranted 2 cycles later
      push_store(32'h80020020, 32'h27BDFFE8);
      push_load(32'h80020014, 4);
      w0 = wr_beats;
      bus.dm_wren = 1'b1; bus.dm_acc_size = 2'b11; bus.dm_addr = 32'h80020020;
      bus.dm_wdata = 32'h27BDFFE8; bus.dm_req = 1'b1;
      wait_grant(0, g, wf);
      bus.dm_wren = 1'b0; bus.dm_acc_size = 2'b01; bus.dm_addr = 32'h80020014;
      wait_grant(0, g2, wf);
      bus.dm_req = 1'b0;
      chk("store_regrant_gap", 32'(g2 - g), 32'd2);
      idle(10);
      chk("store_write_beats", 32'(wr_beats - w0), 32'd1);

      // Contention: both requests held, stores re-requested after each grant
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < 3; j++)
            push_store(32'h80020040 + 32'(4 * (r * 3 + j)), 32'hC0DE0000 + 32'(r * 3 + j));
         push_fetch(32'h80020100, 1);
      end
      k = 0;
      order = '0;
      bus.dm_wren = 1'b1; bus.dm_acc_size = 2'b00;
      bus.dm_addr = 32'h80020040; bus.dm_wdata = 32'hC0DE0000;
      bus.if_addr = 32'h80020100; bus.if_acc_size = 2'b00;
      bus.if_req = 1'b1; bus.dm_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_grant(2, g, wf);
         order = {order[6:0], wf};
         if (!wf) begin
            k++;
            bus.dm_addr  = 32'h80020040 + 32'(4 * k);
            bus.dm_wdata = 32'hC0DE0000 + 32'(k);
         end
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      chk("contention_order", {24'b0, order}, 32'h00000011);
      idle(6);

      // Address wrap across 2^32
      push_fetch(32'hFFFFFFF8, 4);
      bus.if_addr = 32'hFFFFFFF8; bus.if_acc_size = 2'b01; bus.if_req = 1'b1;
      wait_grant(1, g, wf);
      bus.if_req = 1'b0;
      idle(8);

      // Asynchronous reset during beat 2 of a 4-word fetch
      exp_grant.push_back(1'b1);
      exp_beat.push_back('{addr: 32'h80020000, wren: 1'b0, data: 32'd0});
      exp_beat.push_back('{addr: 32'h80020004, wren: 1'b0, data: 32'd0});
      exp_if.push_back(mem_word(32'h80020000));
      bus.if_addr = 32'h80020000; bus.if_acc_size = 2'b01; bus.if_req = 1'b1;
      wait_grant(1, g, wf);
      bus.if_req = 1'b0;
      wait_addr(32'h80020008);
      rst = 1'b1;
      #1;
      chk_zero("midreset");
      idle(1);
      rst = 1'b0;
      idle(6);
      push_fetch(32'h80020004, 1);
      bus.if_addr = 32'h80020004; bus.if_acc_size = 2'b00; bus.if_req = 1'b1;
      req_c = cyc;
      wait_grant(1, g, wf);
      bus.if_req = 1'b0;
      chk("post_reset_grant_latency", 32'(g - req_c), 32'd1);
      idle(6);

      chk("left_grants", 32'(exp_grant.size()), 32'd0);
      chk("left_beats", 32'(exp_beat.size()), 32'd0);
      chk("left_if_words", 32'(exp_if.size()), 32'd0);
      chk("left_dm_words", 32'(exp_dm.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
